// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone memory slave.
// Contents:
//   WB_AW, WB_DW    default address/data widths
//   WB_WS_W         width of the wait-state counter (supports 0..15 wait states)
//   wb_slv_state_e  slave FSM states
package wb_pkg;

    localparam int unsigned WB_AW   = 26;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_WS_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_slv_state_e;

endpackage

// File: rtl/wb_slave_ram.sv
// Word-addressed storage behind the Wishbone slave. Synchronous write, asynchronous
// read, no reset of the contents.
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable
//   addr_i   word index (shared by read and write)
//   wdata_i  write data
//   rdata_o  combinational read data at addr_i
module wb_slave_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave fronting an on-chip memory window with programmable wait states.
// A request accepted in IDLE is latched, held for WAIT_CYCLES extra cycles in WAIT, then
// completed by a one-cycle registered ack (or err) pulse from RESP.
// Optional feature: define WB_SLAVE_ERR_EN to answer out-of-window accesses with err_o
// instead of ack_o; otherwise err_o is always 0 and misses ack (reads return 0).
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active low
//   adr_i/dat_i    word address / write data from master
//   we_i           1 = write, 0 = read
//   stb_i/cyc_i    strobe / bus cycle
//   tagn_i         tag from master, returned on tagn_o with the acknowledge
//   dat_o          registered read data, held until the next read acknowledge
//   ack_o/err_o    one-cycle acknowledge / error acknowledge
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int unsigned    AW          = WB_AW,
    parameter int unsigned    DW          = WB_DW,
    parameter logic [AW-1:0]  BASE_ADDR   = '0,
    parameter int unsigned    DEPTH       = 256,
    parameter int unsigned    WAIT_CYCLES = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] dat_o,
    input  logic          we_i,
    input  logic          stb_i,
    input  logic          cyc_i,
    input  logic          tagn_i,
    output logic          ack_o,
    output logic          tagn_o,
    output logic          err_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    // One extra bit so a window ending exactly at 2**AW is representable.
    localparam logic [AW:0] EndAddr = {1'b0, BASE_ADDR} + (AW+1)'(DEPTH);

    if (EndAddr > {1'b1, {AW{1'b0}}}) begin : g_chk_range
        $error("BASE_ADDR + DEPTH overflows the address width");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (WAIT_CYCLES > 15) begin : g_chk_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    wb_slv_state_e        state_q, state_d;
    logic [WB_WS_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]        idx_q;
    logic                 we_q, tag_q, hit_q;
    logic [DW-1:0]        wdat_q;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 tagn_q, tagn_d;
    logic [DW-1:0]        rdat_q, rdat_d;
    logic                 latch_en;
    logic                 mem_we;
    logic                 hit;
    logic [IW-1:0]        idx;
    logic [DW-1:0]        ram_rdata;

    assign hit = (adr_i >= BASE_ADDR) && ({1'b0, adr_i} < EndAddr);
    assign idx = IW'(adr_i - BASE_ADDR);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        tagn_d   = 1'b0;
        rdat_d   = rdat_q;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A strobe still held during the ack cycle belongs to the finished transfer.
                if (cyc_i && stb_i && !ack_q && !err_q) begin
                    latch_en = 1'b1;
                    cnt_d    = WB_WS_W'(WAIT_CYCLES);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!cyc_i || !stb_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Completes regardless of cyc_i: the transfer is committed once here.
                state_d = IDLE;
                tagn_d  = tag_q;
`ifdef WB_SLAVE_ERR_EN
                if (!hit_q) begin
                    err_d = 1'b1;
                end else begin
                    ack_d  = 1'b1;
                    mem_we = we_q;
                    if (!we_q) begin
                        rdat_d = ram_rdata;
                    end
                end
`else
                ack_d  = 1'b1;
                mem_we = we_q && hit_q;
                if (!we_q) begin
                    rdat_d = hit_q ? ram_rdata : '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            tag_q   <= 1'b0;
            hit_q   <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            tagn_q  <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            tagn_q  <= tagn_d;
            rdat_q  <= rdat_d;
            if (latch_en) begin
                idx_q  <= idx;
                we_q   <= we_i;
                tag_q  <= tagn_i;
                hit_q  <= hit;
                wdat_q <= dat_i;
            end
        end
    end

    wb_slave_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (wdat_q),
        .rdata_o (ram_rdata)
    );

    assign dat_o  = rdat_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign tagn_o = tagn_q;

endmodule
